// File: rtl/step_clock.sv
// Step sequencer clock: divides clk by max(period,2) into step ticks and walks a
// 4-bit step counter that loops from 0 to last_step. The FSM state is visible on running.
module step_clock #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          last_step,
  output logic [3:0]          counter,
  output logic                step_tick,
  output logic                running
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] div_q, div_d;
  logic [PERIOD_W-1:0] p_m1;
  logic [3:0]          counter_q, counter_d;
  logic [3:0]          counter_inc;
  logic                tick_q, tick_d;

  // Terminal divider count; periods 0 and 1 behave as 2.
  assign p_m1 = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);

  // Using >= also handles a last_step lowered below the current counter.
  assign counter_inc = (counter_q >= last_step) ? 4'd0 : counter_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    counter_d = counter_q;
    tick_d    = 1'b0;
    if (restart) begin
      state_d   = run ? RUNNING : STOPPED;
      counter_d = 4'd0;
      div_d     = '0;
      // Back-to-back ticks are never emitted, so a restart landing right after a tick stays silent.
      tick_d    = run && !tick_q;
    end else begin
      case (state_q)
        STOPPED: begin
          div_d = '0;
          if (run) begin
            state_d = RUNNING;
            tick_d  = 1'b1;
          end
        end
        RUNNING: begin
          if (!run) begin
            state_d = STOPPED;
            div_d   = '0;
          end else if (div_q >= p_m1) begin
            div_d     = '0;
            tick_d    = 1'b1;
            counter_d = counter_inc;
          end else begin
            div_d = div_q + PERIOD_W'(1);
          end
        end
        default: state_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= STOPPED;
      div_q     <= '0;
      counter_q <= 4'd0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      counter_q <= counter_d;
      tick_q    <= tick_d;
    end
  end

  assign counter   = counter_q;
  assign step_tick = tick_q;
  assign running   = (state_q == RUNNING);

endmodule

// File: tb/tb_step_clock.sv
// Bench for step_clock: directed scenarios plus random play/pause/restart/reset traffic,
// checked against a cycle-level behavioural model through expected queues.
module tb_step_clock;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n, run, restart;
  logic [PW-1:0] period;
  logic [3:0]    last_step;
  logic [3:0]    counter;
  logic          step_tick;
  logic          running;

  step_clock #(.PERIOD_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .restart  (restart),
    .period   (period),
    .last_step(last_step),
    .counter  (counter),
    .step_tick(step_tick),
    .running  (running)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  logic [5:0] cyc_q[$];

  // Behavioural model: playing flag, cycles elapsed since the last step, step index.
  bit m_play, m_tick;
  int m_cnt, m_el;
  int cur_per, cur_last;

  task automatic drive(input bit rn, input bit r, input bit rs, input int per, input int ls);
    int p;
    @(negedge clk);
    rst_n     = rn;
    run       = r;
    restart   = rs;
    period    = PW'(per);
    last_step = 4'(ls);
    cur_per   = per;
    cur_last  = ls;
    p = (per < 2) ? 2 : per;
    if (!rn) begin
      m_play = 0; m_cnt = 0; m_el = 0; m_tick = 0;
    end else if (rs) begin
      m_cnt  = 0;
      m_el   = 0;
      m_tick = r && !m_tick;
      m_play = r;
    end else if (!m_play) begin
      m_el   = 0;
      m_tick = r;
      m_play = r;
    end else if (!r) begin
      m_play = 0; m_el = 0; m_tick = 0;
    end else begin
      m_el   = m_el + 1;
      m_tick = 0;
      if (m_el >= p) begin
        m_el   = 0;
        m_tick = 1;
        m_cnt  = (m_cnt >= ls) ? 0 : m_cnt + 1;
      end
    end
    if (m_tick) exp_q.push_back(4'(m_cnt));
    cyc_q.push_back({m_play, m_tick, 4'(m_cnt)});
  endtask

  task automatic hold(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b1, r, 1'b0, cur_per, cur_last);
  endtask

  task automatic check_reached(input bit ok, input string name);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: wait bound expired, got not-reached, required reached", name);
    end
  endtask

  // Monitor: one state record per cycle, one counter value per presented step_tick.
  logic [5:0] e;
  logic [3:0] x;
  logic       prev_tick = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        n_tests++;
        if ({running, step_tick, counter} !== e) begin
          n_fail++;
          $display("FAIL cycle_state @%0t: got running=%0b tick=%0b counter=%0d, required running=%0b tick=%0b counter=%0d",
                   $time, running, step_tick, counter, e[5], e[4], e[3:0]);
        end
      end
      if (step_tick === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tick_unexpected @%0t: got step_tick=1 counter=%0d, required no tick", $time, counter);
        end else begin
          x = exp_q.pop_front();
          if (counter !== x) begin
            n_fail++;
            $display("FAIL tick_counter @%0t: got %0d, required %0d", $time, counter, x);
          end
        end
        n_tests++;
        if (prev_tick === 1'b1) begin
          n_fail++;
          $display("FAIL tick_consecutive @%0t: got two ticks in a row, required isolated tick", $time);
        end
      end
      prev_tick = step_tick;
    end
  end

  initial begin
    int i;
    cur_per = 4; cur_last = 15;
    // Reset, then play at period 4 across a full 16-step wrap.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 4, 15);
    hold(4 * 17 + 2, 1'b1);

    // Loop length 4, then shrink to 2 while sitting on step 3.
    drive(1'b1, 1'b1, 1'b1, 4, 3);
    hold(80, 1'b1);
    for (i = 0; i < 40 && m_cnt != 3; i++) hold(1, 1'b1);
    check_reached(m_cnt == 3, "wait_cnt3");
    drive(1'b1, 1'b1, 1'b0, 4, 1);
    hold(14, 1'b1);

    // Pause on step 5 for 10 cycles, then resume.
    drive(1'b1, 1'b1, 1'b0, 4, 15);
    for (i = 0; i < 200 && !(m_cnt == 5 && m_el == 1); i++) hold(1, 1'b1);
    check_reached(m_cnt == 5, "wait_cnt5");
    hold(10, 1'b0);
    hold(12, 1'b1);

    // Restart exactly on an edge where step 7 would advance.
    for (i = 0; i < 200 && !(m_cnt == 7 && m_el == 3); i++) hold(1, 1'b1);
    check_reached(m_cnt == 7 && m_el == 3, "wait_advance7");
    drive(1'b1, 1'b1, 1'b1, 4, 15);
    hold(10, 1'b1);

    // Degenerate periods, then a long period cut short mid-step.
    drive(1'b1, 1'b1, 1'b0, 0, 15);
    hold(10, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1, 15);
    hold(10, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 100, 15);
    for (i = 0; i < 300 && m_el != 50; i++) hold(1, 1'b1);
    check_reached(m_el == 50, "wait_div50");
    drive(1'b1, 1'b1, 1'b0, 3, 15);
    hold(12, 1'b1);

    // Reset mid-step on step 9 with run held high.
    drive(1'b1, 1'b1, 1'b0, 4, 15);
    for (i = 0; i < 200 && !(m_cnt == 9 && m_el == 2); i++) hold(1, 1'b1);
    check_reached(m_cnt == 9, "wait_cnt9");
    drive(1'b0, 1'b1, 1'b0, 4, 15);
    hold(10, 1'b1);

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      int per, ls;
      bit rn, r, rs;
      per = cur_per;
      ls  = cur_last;
      if ($urandom_range(0, 99) < 4) per = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
      if ($urandom_range(0, 99) < 3) ls = $urandom_range(0, 15);
      rn = ($urandom_range(0, 199) != 0);
      r  = ($urandom_range(0, 99) < 90);
      rs = ($urandom_range(0, 99) < 3);
      drive(rn, r, rs, per, ls);
    end

    hold(2, 1'b0);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ticks_missing: got %0d ticks outstanding, required 0", exp_q.size());
    end
    n_tests++;
    if (cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL cycles_unchecked: got %0d outstanding, required 0", cyc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_clock.md
STEP_CLOCK -- requirements
Module: step_clock

Interface
REQ-001 SHALL have parameter PERIOD_W, default 24, width of the step-period input and internal divider.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port run  input  1  level; 1 = sequencer playing, 0 = paused.
REQ-005 SHALL have port restart  input  1  single-cycle pulse; return to step 0.
REQ-006 SHALL have port period  input  PERIOD_W  clk cycles per step.
REQ-007 SHALL have port last_step  input  4  highest step index before wrap; loop length = last_step+1.
REQ-008 SHALL have port counter  output  4  current step index, feeds the 16-way note trigger stage.
REQ-009 SHALL have port step_tick  output  1  one-cycle pulse, high in the cycle a new step begins.
REQ-010 SHALL have port running  output  1  high while in RUNNING state.

Function
REQ-011 SHALL implement two states, STOPPED and RUNNING, plus an internal divider div (PERIOD_W bits); all outputs registered.
REQ-012 SHALL use effective period P = max(period, 2); period 0 or 1 behaves as 2.
REQ-013 SHALL, in STOPPED with run=1, enter RUNNING next edge, clear div, assert step_tick for that cycle, counter unchanged (start tick sounds current step).
REQ-014 SHALL, in STOPPED with run=0, hold counter, div=0, step_tick=0.
REQ-015 SHALL, in RUNNING, increment div each cycle; when div >= P-1: div<=0, step_tick<=1, counter advances.
REQ-016 SHALL advance counter as: counter >= last_step -> 0, else counter+1 (covers last_step lowered below current counter and 4-bit wrap 15->0).
REQ-017 SHALL yield exactly P cycles between consecutive step_ticks while run stays 1 and period constant.
REQ-018 SHALL apply period changes immediately; if new P-1 <= current div, advance on the next edge.
REQ-019 SHALL, in RUNNING with run=0, enter STOPPED next edge, clear div, hold counter, no step_tick (pause; resume per REQ-013).
REQ-020 SHALL, on restart=1: counter<=0, div<=0; step_tick<=1 if the next state is RUNNING, else 0; restart overrides a coincident advance.
REQ-021 SHALL, on restart coincident with run rising in STOPPED, enter RUNNING with counter=0 and a single step_tick.
REQ-022 SHALL never assert step_tick on two consecutive cycles.
REQ-023 SHALL keep running = (state == RUNNING), updated on the same edge as the state.

Reset
REQ-024 SHALL, with rst_n=0 at a clk edge: state STOPPED, counter=0, div=0, step_tick=0, running=0; reset overrides run and restart.
REQ-025 SHALL, on reset asserted mid-step, discard the partial div count; after release with run=1, first step_tick one cycle later, counter=0.

Verification
REQ-026 Reset then run=1, period=4, last_step=15 -> step_tick at cycle 1 (counter 0), then every 4 cycles counter 1,2,3...; after 15 wraps to 0.
REQ-027 period=4, last_step=3, run 20 steps -> counter sequence 0,1,2,3,0,... ; lower last_step to 1 while counter=3 -> next tick counter 0.
REQ-028 Running, counter=5, run=0 for 10 cycles then 1 -> no ticks while paused, running=0, counter stays 5; resume tick with counter 5, next tick 6 after P cycles.
REQ-029 restart pulsed on same cycle as a due advance, counter=7 -> counter 0, single step_tick, next tick P cycles later with counter 1.
REQ-030 period=0 and period=1 -> ticks every 2 cycles; period changed 100->3 when div=50 -> tick next cycle, then every 3.
REQ-031 rst_n=0 mid-step with counter=9 -> all outputs zero next edge; run held 1 after release -> tick with counter 0 one cycle after release.
